strip_trigger_queue: RTL and testbench

- Upstream feeder for strip_trigger_gen.
- Accepts strip trigger candidates (BCID, phi id, band id) from the trigger-finding logic and buffers them in a small FIFO.
- Discards candidates too old to be useful, and hands each surviving candidate to strip_trigger_gen using that block's load/ready handshake.
- Runs entirely in the clk_slow domain.

---
 rtl/strip_trig_pkg.sv | 27 ++
 rtl/strip_trig_fifo.sv | 70 +++++++
 rtl/strip_trigger_queue.sv | 140 ++++++++++++++
 tb/tb_strip_trigger_queue.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/strip_trig_pkg.sv
// Shared types and widths for the strip trigger candidate queue.
package strip_trig_pkg;

    localparam int unsigned BCID_W = 12;
    localparam int unsigned PHI_W  = 5;
    localparam int unsigned BAND_W = 8;

    typedef struct packed {
        logic [BCID_W-1:0] bcid;
        logic [PHI_W-1:0]  phi;
        logic [BAND_W-1:0] band;
    } cand_t;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWaitBusy,
        StWaitDone
    } state_e;

    // Bunch-crossing distance with natural 12-bit wrap.
    function automatic logic [BCID_W-1:0] bcid_age(input logic [BCID_W-1:0] cur,
                                                   input logic [BCID_W-1:0] cand);
        return cur - cand;
    endfunction

endpackage

// File: rtl/strip_trig_fifo.sv
// Small synchronous FIFO with combinational head and registered level/full.
module strip_trig_fifo #(
    parameter int unsigned AW = 3,
    parameter int unsigned W  = 25
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic [AW:0]  level_o,
    output logic         full_o
);

    localparam logic [AW:0] Depth = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem_q [1 << AW];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          full_q, full_d;
    logic          push_ok, pop_ok;

    assign push_ok = push_i && (level_q != Depth);
    assign pop_ok  = pop_i && (level_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            level_d = level_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            level_d = level_q - 1'b1;
        end
        full_d = (level_d == Depth);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign full_o  = full_q;

endmodule

// File: rtl/strip_trigger_queue.sv
// Buffers strip trigger candidates, discards stale ones and feeds survivors to
// strip_trigger_gen over its load/ready handshake.
module strip_trigger_queue
    import strip_trig_pkg::*;
#(
    parameter int unsigned AW           = 3,
    parameter int unsigned MAX_AGE      = 16,
    parameter int unsigned BUSY_TIMEOUT = 64
) (
    input  logic          clk_slow,
    input  logic          reset_n,
    input  logic          cand_valid,
    input  logic [11:0]   cand_bcid,
    input  logic [4:0]    cand_phi,
    input  logic [7:0]    cand_band,
    input  logic [11:0]   cur_bcid,
    input  logic          ready,
    output logic          load,
    output logic [11:0]   trigger_content_BCID,
    output logic [4:0]    phi_id,
    output logic [7:0]    bandid,
    output logic          cand_full,
    output logic [AW:0]   fifo_level,
    output logic [15:0]   drop_count,
    output logic [15:0]   stale_count
);

    localparam int unsigned       TW          = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [TW-1:0]     TimeoutLast = TW'(BUSY_TIMEOUT - 1);
    localparam logic [BCID_W-1:0] MaxAge      = BCID_W'(MAX_AGE);

    cand_t       cand_in, head;
    logic        push, pop, full, stale;
    logic [AW:0] level;

    state_e        state_q, state_d;
    logic          load_q, load_d;
    cand_t         out_q, out_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [15:0]   drop_q, drop_d;
    logic [15:0]   stale_q, stale_d;

    assign cand_in = '{bcid: cand_bcid, phi: cand_phi, band: cand_band};
    assign push    = cand_valid && !full;

    strip_trig_fifo #(
        .AW (AW),
        .W  ($bits(cand_t))
    ) u_fifo (
        .clk_i   (clk_slow),
        .rst_ni  (reset_n),
        .push_i  (push),
        .data_i  (cand_in),
        .pop_i   (pop),
        .head_o  (head),
        .level_o (level),
        .full_o  (full)
    );

    assign stale = bcid_age(cur_bcid, head.bcid) > MaxAge;

    always_comb begin
        state_d = state_q;
        load_d  = 1'b0;
        out_d   = out_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        stale_d = stale_q;
        pop     = 1'b0;

        // A full FIFO drops the candidate even if the head is popped this cycle.
        if (cand_valid && full && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end

        unique case (state_q)
            StIdle: begin
                if ((level != '0) && ready) begin
                    pop = 1'b1;
                    if (stale) begin
                        if (stale_q != 16'hFFFF) begin
                            stale_d = stale_q + 16'd1;
                        end
                    end else begin
                        out_d   = head;
                        load_d  = 1'b1;
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                cnt_d   = '0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (!ready) begin
                    state_d = StWaitDone;
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_slow or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            load_q  <= 1'b0;
            out_q   <= '0;
            cnt_q   <= '0;
            drop_q  <= '0;
            stale_q <= '0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            stale_q <= stale_d;
        end
    end

    assign load                 = load_q;
    assign trigger_content_BCID = out_q.bcid;
    assign phi_id               = out_q.phi;
    assign bandid               = out_q.band;
    assign cand_full            = full;
    assign fifo_level           = level;
    assign drop_count           = drop_q;
    assign stale_count          = stale_q;

endmodule

// File: tb/tb_strip_trigger_queue.sv
// Self-checking bench: directed vectors, corner-case sequences and random traffic
// compared every cycle against a timestamp-based queue model.
module tb_strip_trigger_queue;

    localparam int MAX_AGE      = 16;
    localparam int BUSY_TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cand_valid;
    logic [11:0] cand_bcid;
    logic [4:0]  cand_phi;
    logic [7:0]  cand_band;
    logic [11:0] cur_bcid;
    logic        ready;
    logic        load;
    logic [11:0] trigger_content_BCID;
    logic [4:0]  phi_id;
    logic [7:0]  bandid;
    logic        cand_full;
    logic [3:0]  fifo_level;
    logic [15:0] drop_count;
    logic [15:0] stale_count;

    always #5 clk = ~clk;

    strip_trigger_queue #(
        .AW           (3),
        .MAX_AGE      (MAX_AGE),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk_slow             (clk),
        .reset_n              (reset_n),
        .cand_valid           (cand_valid),
        .cand_bcid            (cand_bcid),
        .cand_phi             (cand_phi),
        .cand_band            (cand_band),
        .cur_bcid             (cur_bcid),
        .ready                (ready),
        .load                 (load),
        .trigger_content_BCID (trigger_content_BCID),
        .phi_id               (phi_id),
        .bandid               (bandid),
        .cand_full            (cand_full),
        .fifo_level           (fifo_level),
        .drop_count           (drop_count),
        .stale_count          (stale_count)
    );

    typedef struct packed {
        logic [11:0] bcid;
        logic [4:0]  phi;
        logic [7:0]  band;
    } mcand_t;

    typedef struct {
        logic [11:0] bcid;
        logic [4:0]  phi;
        logic [7:0]  band;
        logic [11:0] cur;
        bit          exp_load;
    } vec_t;

    int n_total = 0;
    int n_pass  = 0;
    int t       = 0;

    // Reference model: queue contents plus the earliest cycle a pop may happen.
    mcand_t      mq[$];
    int          m_drop, m_stale;
    logic [24:0] m_out;
    bit          m_load;
    int          m_earliest;
    bit          m_watch, m_seen_low;
    int          m_wb_start;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, t);
    endtask

    function automatic int age_of(input int cur, input int bcid);
        return (cur + 4096 - bcid) % 4096;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_drop     = 0;
        m_stale    = 0;
        m_out      = '0;
        m_load     = 1'b0;
        m_earliest = 0;
        m_watch    = 1'b0;
        m_seen_low = 1'b0;
        m_wb_start = 0;
    endtask

    task automatic model_update();
        int     sz;
        bit     nl;
        mcand_t h;
        sz = mq.size();
        nl = 1'b0;
        // Consumer-busy tracking: wait for ready to drop then rise, or time out.
        if (m_watch && t >= m_wb_start) begin
            if (m_seen_low) begin
                if (ready) begin
                    m_watch    = 1'b0;
                    m_earliest = t + 1;
                end
            end else if (!ready) begin
                m_seen_low = 1'b1;
            end else if (t - m_wb_start + 1 >= BUSY_TIMEOUT) begin
                m_watch    = 1'b0;
                m_earliest = t + 1;
            end
        end
        if (!m_watch && t >= m_earliest && sz > 0 && ready) begin
            h = mq.pop_front();
            if (age_of(int'(cur_bcid), int'(h.bcid)) > MAX_AGE) begin
                if (m_stale < 65535) m_stale++;
            end else begin
                m_out      = h;
                nl         = 1'b1;
                m_watch    = 1'b1;
                m_seen_low = 1'b0;
                m_wb_start = t + 2;
            end
        end
        if (cand_valid) begin
            if (sz == 8) begin
                if (m_drop < 65535) m_drop++;
            end else begin
                mq.push_back({cand_bcid, cand_phi, cand_band});
            end
        end
        m_load = nl;
    endtask

    task automatic check_outputs();
        chk("load", 32'(load), 32'(m_load));
        chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
        chk("cand_full", 32'(cand_full), 32'(mq.size() == 8));
        chk("drop_count", 32'(drop_count), 32'(m_drop));
        chk("stale_count", 32'(stale_count), 32'(m_stale));
        chk("out_data", 32'({trigger_content_BCID, phi_id, bandid}), 32'(m_out));
    endtask

    // Called #1 after a rising edge with the cycle's inputs already applied.
    task automatic step();
        check_outputs();
        if (reset_n) model_update();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic set_cand(input bit v, input logic [11:0] b, input logic [4:0] p,
                            input logic [7:0] bd);
        cand_valid = v;
        cand_bcid  = b;
        cand_phi   = p;
        cand_band  = bd;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[8];
        int          s0, d0, k, lows, nl, busy_left, hold_hi;
        bit          pl;
        logic [11:0] cur_r;

        vecs[0] = '{12'hAC5, 5'h1F, 8'hFF, 12'hAC7, 1'b1};
        vecs[1] = '{12'hFF8, 5'h03, 8'h11, 12'h009, 1'b0};
        vecs[2] = '{12'hFF8, 5'h04, 8'h22, 12'h008, 1'b1};
        vecs[3] = '{12'h000, 5'h00, 8'h00, 12'h000, 1'b1};
        vecs[4] = '{12'h100, 5'h0A, 8'h5A, 12'h110, 1'b1};
        vecs[5] = '{12'h100, 5'h0B, 8'h5B, 12'h111, 1'b0};
        vecs[6] = '{12'hFFF, 5'h15, 8'hA5, 12'h00F, 1'b1};
        vecs[7] = '{12'hFFF, 5'h16, 8'hA6, 12'h010, 1'b0};

        reset_n = 1'b0;
        set_cand(1'b0, '0, '0, '0);
        cur_bcid = '0;
        ready    = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        reset_n = 1'b1;

        // Single-candidate vectors into an idle, empty queue.
        foreach (vecs[i]) begin
            s0       = m_stale;
            cur_bcid = vecs[i].cur;
            ready    = 1'b1;
            set_cand(1'b1, vecs[i].bcid, vecs[i].phi, vecs[i].band);
            step();
            cand_valid = 1'b0;
            step();
            chk("vec_load", 32'(load), 32'(vecs[i].exp_load));
            if (vecs[i].exp_load)
                chk("vec_data", 32'({trigger_content_BCID, phi_id, bandid}),
                    32'({vecs[i].bcid, vecs[i].phi, vecs[i].band}));
            chk("vec_stale", 32'(stale_count), 32'(s0 + (vecs[i].exp_load ? 0 : 1)));
            step();
            ready = 1'b0;
            step();
            ready = 1'b1;
            repeat (3) step();
        end

        // Overflow: ten pushes against a stalled consumer, then drain in order.
        d0       = m_drop;
        ready    = 1'b0;
        cur_bcid = 12'h20A;
        for (int i = 0; i < 10; i++) begin
            set_cand(1'b1, 12'h200 + 12'(i), 5'(i), 8'h10 + 8'(i));
            step();
        end
        cand_valid = 1'b0;
        chk("ovf_level", 32'(fifo_level), 32'd8);
        chk("ovf_full", 32'(cand_full), 32'd1);
        chk("ovf_drop", 32'(drop_count), 32'(d0 + 2));
        k  = 0;
        pl = 1'b0;
        repeat (50) begin
            ready = !pl;
            pl    = m_load;
            if (load) begin
                if (k < 8)
                    chk("ovf_order", 32'({trigger_content_BCID, phi_id, bandid}),
                        32'({12'h200 + 12'(k), 5'(k), 8'h10 + 8'(k)}));
                k++;
            end
            step();
        end
        chk("ovf_loads", 32'(k), 32'd8);
        ready = 1'b1;
        repeat (3) step();

        // Handshake: consumer busy for 20 cycles after the first load.
        cur_bcid = 12'h302;
        ready    = 1'b1;
        set_cand(1'b1, 12'h300, 5'h01, 8'h01);
        step();
        set_cand(1'b1, 12'h301, 5'h02, 8'h02);
        step();
        cand_valid = 1'b0;
        chk("hs_first_load", 32'(load), 32'd1);
        step();
        ready = 1'b0;
        lows  = 0;
        repeat (20) begin
            lows += int'(load);
            step();
        end
        chk("hs_no_load", 32'(lows), 32'd0);
        ready = 1'b1;
        step();
        step();
        chk("hs_reload", 32'(load), 32'd1);
        chk("hs_data", 32'({trigger_content_BCID, phi_id, bandid}),
            32'({12'h301, 5'h02, 8'h02}));
        step();
        ready = 1'b0;
        step();
        ready = 1'b1;
        repeat (4) step();

        // Timeout: ready never drops after the load.
        cur_bcid = 12'h402;
        set_cand(1'b1, 12'h400, 5'h05, 8'h40);
        step();
        set_cand(1'b1, 12'h401, 5'h06, 8'h41);
        step();
        cand_valid = 1'b0;
        chk("to_first_load", 32'(load), 32'd1);
        repeat (65) step();
        chk("to_early", 32'(load), 32'd0);
        step();
        chk("to_reload", 32'(load), 32'd1);
        step();
        ready = 1'b0;
        step();
        ready = 1'b1;
        repeat (4) step();

        // Asynchronous reset while waiting for the consumer with 3 entries queued.
        cur_bcid = 12'h503;
        ready    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) ready = 1'b0;
            set_cand(1'b1, 12'h500 + 12'(i), 5'(i + 8), 8'h50 + 8'(i));
            step();
        end
        cand_valid = 1'b0;
        step();
        chk("rst_pre_level", 32'(fifo_level), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_data", 32'({trigger_content_BCID, phi_id, bandid}), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_full", 32'(cand_full), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_stale", 32'(stale_count), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        t++;
        ready = 1'b1;
        repeat (2) step();
        reset_n = 1'b1;
        nl = 0;
        repeat (10) begin
            nl += int'(load);
            step();
        end
        chk("rst_no_load", 32'(nl), 32'd0);

        // Random traffic with a randomly-busy consumer; BCID wraps mid-run.
        cur_r     = 12'hF80;
        busy_left = 0;
        hold_hi   = 0;
        repeat (3000) begin
            cur_bcid   = cur_r;
            cur_r      = cur_r + 12'd1;
            cand_valid = ($urandom_range(0, 99) < 45);
            cand_bcid  = cur_bcid - 12'($urandom_range(0, 22));
            cand_phi   = 5'($urandom);
            cand_band  = 8'($urandom);
            if (hold_hi > 0) begin
                ready = 1'b1;
                hold_hi--;
            end else if (busy_left > 0) begin
                ready = 1'b0;
                busy_left--;
            end else begin
                ready = ($urandom_range(0, 15) != 0);
            end
            if (m_load) begin
                if ($urandom_range(0, 7) == 0) hold_hi = 70;
                else busy_left = $urandom_range(1, 5);
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
